// File: rtl/icache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// icache_ctrl_pkg
// Shared definitions for the direct-mapped instruction cache controller:
//   - default geometry (LINES, WORDS)
//   - FSM state encoding (IDLE, LOOKUP, REFILL, RESPOND)
//   - helper that derives the tag width from the geometry
// Optional feature macro used by the slice: ICACHE_STATS_EN (hit/miss counters).
// ---------------------------------------------------------------------------
package icache_ctrl_pkg;

    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        REFILL  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // Tag bits left over once the byte offset, word offset and index are removed.
    function automatic int tag_width(input int lines, input int words);
        return 30 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_ctrl_tag_ram.sv
// ---------------------------------------------------------------------------
// icache_tag_ram
// Tag and valid-bit storage for the instruction cache, one entry per line.
// Ports:
//   clk       system clock
//   clear     synchronous clear of every valid bit (reset or flush)
//   rd_index  line index looked up combinationally
//   rd_tag    stored tag of rd_index
//   rd_valid  valid bit of rd_index
//   wr_en     write wr_tag into wr_index and mark the line valid
//   wr_index  line index written
//   wr_tag    tag written
// Tags are never reset; only the valid bits are.
// ---------------------------------------------------------------------------
module icache_tag_ram #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_index,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [TAG_W-1:0] tags [LINES];
    logic [LINES-1:0] valid;

    // Clear wins over a same-cycle fill so a reset during the last refill
    // beat leaves the line invalid.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
        end
    end

    assign rd_tag   = tags[rd_index];
    assign rd_valid = valid[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// ---------------------------------------------------------------------------
// icache_ctrl
// Direct-mapped read-only instruction cache between the fetch stage and a
// slow instruction memory. Misses stall the CPU while the whole line is
// refilled word by word over a req/ack handshake.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cpu_req, cpu_addr    fetch request and byte address (bits [1:0] ignored)
//   cpu_data, cpu_valid  returned instruction, one-cycle valid pulse
//   cpu_stall            request accepted and not yet answered
//   flush                invalidate all lines (deferred while busy)
//   mem_req, mem_addr    backing-memory word read request
//   mem_rdata, mem_ack   backing-memory data and one-cycle completion
//   hit_count,miss_count statistics, built only with ICACHE_STATS_EN defined,
//                        otherwise tied to zero
// ---------------------------------------------------------------------------
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_data,
    output logic        cpu_valid,
    output logic        cpu_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = tag_width(LINES, WORDS);

    state_t           state;
    logic [31:0]      addr_q;
    logic [OFF_W-1:0] fill_cnt;
    logic [OFF_W-1:0] fill_next;
    logic             flush_pend;
    logic [31:0]      data_arr [LINES][WORDS];

    logic [OFF_W-1:0] req_word;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-1:0] q_word;
    logic [IDX_W-1:0] q_idx;
    logic [TAG_W-1:0] q_tag;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             hit_now;
    logic             fill_we;
    logic             last_beat;
    logic             going_idle;
    logic             clear_all;
    logic             unused_bits;

    assign req_word = cpu_addr[OFF_W+1:2];
    assign req_idx  = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag  = cpu_addr[31:OFF_W+IDX_W+2];
    assign q_word   = addr_q[OFF_W+1:2];
    assign q_idx    = addr_q[OFF_W+IDX_W+1:OFF_W+2];
    assign q_tag    = addr_q[31:OFF_W+IDX_W+2];

    assign unused_bits = ^{cpu_addr[1:0], addr_q[1:0]};

    // The lookup is resolved as the request is accepted so that the hit
    // response is already registered during the LOOKUP cycle. A flush in the
    // same cycle wipes the line at that edge, so it forces a miss.
    assign hit_now   = rd_valid && (rd_tag == req_tag) && !flush;
    assign fill_we   = (state == REFILL) && mem_req && mem_ack;
    assign last_beat = fill_we && (fill_cnt == OFF_W'(WORDS - 1));
    assign fill_next = fill_cnt + OFF_W'(1);

    // A flush raised while busy is applied on the edge that returns to IDLE.
    assign going_idle = ((state == LOOKUP) && cpu_valid) || (state == RESPOND);
    assign clear_all  = rst
                     || (flush && (state == IDLE))
                     || (going_idle && (flush || flush_pend));

    icache_tag_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_ram (
        .clk      (clk),
        .clear    (clear_all),
        .rd_index (req_idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (last_beat && !rst),
        .wr_index (q_idx),
        .wr_tag   (q_tag)
    );

    // Line data is never reset; a partially filled line stays invalid.
    always_ff @(posedge clk) begin
        if (!rst && fill_we) begin
            data_arr[q_idx][fill_cnt] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            fill_cnt   <= '0;
            flush_pend <= 1'b0;
            cpu_valid  <= 1'b0;
            cpu_stall  <= 1'b0;
            cpu_data   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_pend <= 1'b0;
                    if (cpu_req) begin
                        addr_q    <= cpu_addr;
                        state     <= LOOKUP;
                        cpu_valid <= hit_now;
                        cpu_stall <= !hit_now;
                        if (hit_now) begin
                            cpu_data <= data_arr[req_idx][req_word];
                        end
                    end
                end
                LOOKUP: begin
                    cpu_valid <= 1'b0;
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (cpu_valid) begin
                        state <= IDLE;
                    end else begin
                        state    <= REFILL;
                        fill_cnt <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= {q_tag, q_idx, {OFF_W{1'b0}}, 2'b00};
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (fill_we) begin
                        fill_cnt <= fill_next;
                        mem_addr <= {q_tag, q_idx, fill_next, 2'b00};
                        if (last_beat) begin
                            mem_req   <= 1'b0;
                            state     <= RESPOND;
                            cpu_valid <= 1'b1;
                            // The requested word may be the one arriving now.
                            cpu_data  <= (q_word == fill_cnt) ? mem_rdata
                                                              : data_arr[q_idx][q_word];
                        end
                    end
                end
                RESPOND: begin
                    cpu_valid  <= 1'b0;
                    cpu_stall  <= 1'b0;
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    // In LOOKUP the registered cpu_valid is the hit/miss outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state == LOOKUP) begin
            if (cpu_valid) begin
                hits_q <= hits_q + 32'd1;
            end else begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign hit_count  = hits_q;
    assign miss_count = misses_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
